// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size codes, FSM states,
// the bus-error fill value and the alignment rule.
package mem_stage_pkg;

    // Access size lives in funct3[1:0]; funct3[2] selects zero-extension for loads.
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MEM_IDLE       = 2'd0,
        MEM_WAIT_GNT   = 2'd1,
        MEM_WAIT_RDATA = 2'd2
    } mem_state_t;

    // Returned as load data when an access is aborted by the timeout.
    localparam logic [31:0] MEM_BUS_ERR_DATA = 32'hbaad_beef;

    // Bytes are always aligned, halfwords need addr[0]==0, words (and any
    // unused size code) need addr[1:0]==0.
    function automatic logic mem_is_aligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic ok;
        case (funct3[1:0])
            MEM_SIZE_B: ok = 1'b1;
            MEM_SIZE_H: ok = ~addr_lo[0];
            default:    ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte enables and lane-replicated write data,
// load byte/halfword extraction with sign or zero extension, alignment flag.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign aligned = mem_is_aligned(funct3, addr_lo);

    // Store lanes: replicate the narrow datum across the word, enable only its bytes.
    always_comb begin
        be    = 4'hF;
        wdata = store_data;
        case (funct3[1:0])
            MEM_SIZE_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SIZE_H: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wdata = store_data;
            end
        endcase
    end

    // Load extract: bring the addressed byte lane down to bit 0, then extend.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (funct3[1:0])
            MEM_SIZE_B: load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            MEM_SIZE_H: load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives the req/gnt/rvalid data port for loads and stores
// coming out of EX/MEM, stalls upstream while an access is outstanding,
// aborts with a one-cycle bus error after a timeout, and passes the ALU
// result straight through for everything else.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_regb,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_rd_mem,
    input  logic        ex_mem_wr_mem,
    input  logic        ex_mem_valid_inst,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] mem_result_out,
    output logic        mem_stall_out,
    output logic        mem_misaligned_out,
    output logic        mem_bus_err_out
);

    // The counter value seen in the last waiting cycle before the abort cycle.
    localparam logic [CNT_W-1:0] LAST_WAIT_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic        aligned;
    logic        mem_access;
    logic        memop;
    logic        is_load;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    logic        req;
    logic        stall;
    logic        misaligned;
    logic [31:0] result;
    logic        active;

    lsu_align u_lsu_align (
        .addr_lo    (ex_mem_alu_result[1:0]),
        .funct3     (ex_mem_funct3),
        .store_data (ex_mem_regb),
        .rdata      (dmem_rdata),
        .aligned    (aligned),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    assign mem_access = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
    assign memop      = mem_access & aligned;
    // A load takes priority should both flags ever be set together.
    assign is_load    = ex_mem_rd_mem;

    // Next-state, timeout bookkeeping and raw (pre-reset-gating) outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        req        = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        result     = ex_mem_alu_result;
        case (state_q)
            MEM_IDLE: begin
                cnt_d      = '0;
                misaligned = mem_access & ~aligned;
                req        = memop;
                if (memop) begin
                    if (dmem_gnt) begin
                        if (is_load) begin
                            stall   = 1'b1;
                            state_d = MEM_WAIT_RDATA;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = MEM_WAIT_GNT;
                    end
                end
            end
            MEM_WAIT_GNT: begin
                if (err_q) begin
                    // Abort cycle: release the pipeline, any late grant is ignored.
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                    if (is_load) result = MEM_BUS_ERR_DATA;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt) begin
                        cnt_d = '0;
                        if (is_load) begin
                            stall   = 1'b1;
                            state_d = MEM_WAIT_RDATA;
                        end else begin
                            state_d = MEM_IDLE;
                        end
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        err_d = (cnt_q == LAST_WAIT_CNT);
                    end
                end
            end
            MEM_WAIT_RDATA: begin
                if (err_q) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                    result  = MEM_BUS_ERR_DATA;
                end else if (dmem_rvalid) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                    result  = load_data;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    err_d = (cnt_q == LAST_WAIT_CNT);
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, timeout counter and the registered abort flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Every output is held at zero while reset is asserted.
    assign active             = rst & req;
    assign dmem_req           = active;
    assign dmem_we            = active & ex_mem_wr_mem & ~ex_mem_rd_mem;
    assign dmem_addr          = active ? {ex_mem_alu_result[31:2], 2'b00} : 32'h0;
    assign dmem_be            = active ? lane_be : 4'h0;
    assign dmem_wdata         = active ? lane_wdata : 32'h0;
    assign mem_result_out     = rst ? result : 32'h0;
    assign mem_stall_out      = rst & stall;
    assign mem_misaligned_out = rst & misaligned;
    assign mem_bus_err_out    = rst & err_q;

endmodule
